bram_tdp_param: RTL and testbench

BRAM_TDP_PARAM -- requirements
Module: bram_tdp_param

---
 rtl/bram_pkg.sv | 19 +
 rtl/bram_clear_fsm.sv | 66 ++++++
 rtl/bram_tdp_param.sv | 156 +++++++++++++++
 tb/tb_bram_tdp_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bram_pkg
//  Purpose  : Shared definitions for the true dual-port block RAM.
//             - state_e : init-sweep FSM states {CLEAR, RUN}
//             - BYTE_W  : width of one byte-write lane
//  Revision : 1.0 - initial release
// ============================================================================
package bram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bram_clear_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : bram_clear_fsm
//  Purpose  : Post-reset initialisation sweep. Walks an address counter over
//             the whole array, one word per cycle, requesting a zero write at
//             each address, then parks in RUN and raises ready_o.
//  Ports    : CLK        - clock
//             RST_N      - asynchronous active-low reset (restarts the sweep)
//             clr_addr_o - address of the current clear write
//             clr_we_o   - clear write strobe (high for the whole sweep)
//             ready_o    - high once the sweep has completed
//  Revision : 1.0 - initial release
// ============================================================================
module bram_clear_fsm
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  clr_we_o,
  output logic                  ready_o
);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;
  logic                  clr_we_q;
  logic                  ready_q;

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      clr_we_q <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_d;
          // Counter wrap marks the final clear write; READY follows next cycle.
          if (cnt_d == '0) begin
            state_q  <= RUN;
            clr_we_q <= 1'b0;
            ready_q  <= 1'b1;
          end
        end
        RUN: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= CLEAR;
        end
      endcase
    end
  end

  assign clr_addr_o = cnt_q;
  assign clr_we_o   = clr_we_q;
  assign ready_o    = ready_q;

endmodule
`default_nettype wire

// File: rtl/bram_tdp_param.sv
`default_nettype none
// ============================================================================
//  Module   : bram_tdp_param
//  Purpose  : Single-clock true dual-port RAM with byte-write enables,
//             READ_FIRST behaviour, same-address collision flag and a
//             zeroing sweep after every reset.
//  Ports    : CLK, RST_N          - clock, asynchronous active-low reset
//             ADDRA/ADDRB         - word addresses
//             DIA/DIB             - write data
//             WEA/WEB             - byte write enables (one bit per lane)
//             ENA/ENB             - access requests (honoured only when READY)
//             DOA/DOB             - read data (holds while VALIDx is low)
//             VALIDA/VALIDB       - DOx carries the word of an accepted access
//             READY               - sweep finished, requests are accepted
//             COLL                - pulse: same address, both ports, any write
//  Config   : `define BRAM_OUTREG_EN adds a second output register stage
//             (read latency 2, VALIDx/COLL delayed to match).
//  Notes    : DATA_WIDTH must be a multiple of 8.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_tdp_param
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [ADDR_WIDTH-1:0]        ADDRA,
  input  logic [ADDR_WIDTH-1:0]        ADDRB,
  input  logic [DATA_WIDTH-1:0]        DIA,
  input  logic [DATA_WIDTH-1:0]        DIB,
  input  logic [DATA_WIDTH/BYTE_W-1:0] WEA,
  input  logic [DATA_WIDTH/BYTE_W-1:0] WEB,
  input  logic                         ENA,
  input  logic                         ENB,
  output logic [DATA_WIDTH-1:0]        DOA,
  output logic [DATA_WIDTH-1:0]        DOB,
  output logic                         VALIDA,
  output logic                         VALIDB,
  output logic                         READY,
  output logic                         COLL
);

  localparam int NB    = DATA_WIDTH / BYTE_W;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;
  logic                  ready;

  bram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_fsm (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .clr_addr_o (clr_addr),
    .clr_we_o   (clr_we),
    .ready_o    (ready)
  );

  logic acc_a;
  logic acc_b;
  logic coll_d;

  assign acc_a  = ENA & ready;
  assign acc_b  = ENB & ready;
  assign coll_d = acc_a & acc_b & (ADDRA == ADDRB) & ((|WEA) | (|WEB));

  // The sweep borrows port A's write path: user requests are never accepted
  // while the sweep runs, so the two uses cannot overlap.
  logic [ADDR_WIDTH-1:0] addr_a_w;
  logic [DATA_WIDTH-1:0] din_a_w;
  logic [NB-1:0]         we_a_w;
  logic [NB-1:0]         we_b_w;

  assign addr_a_w = ready ? ADDRA : clr_addr;
  assign din_a_w  = ready ? DIA   : '0;
  assign we_a_w   = ready ? (acc_a ? WEA : '0) : {NB{clr_we}};
  assign we_b_w   = acc_b ? WEB : '0;

  // Array: no reset, content defined only by the sweep and user writes.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Port B lanes are written first so that port A, written after, takes any
  // lane both ports target at the same address.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NB; i++) begin
      if (we_b_w[i]) mem_q[ADDRB][i*BYTE_W +: BYTE_W] <= DIB[i*BYTE_W +: BYTE_W];
      if (we_a_w[i]) mem_q[addr_a_w][i*BYTE_W +: BYTE_W] <= din_a_w[i*BYTE_W +: BYTE_W];
    end
  end

  // First read stage: samples the pre-write word (READ_FIRST), holds otherwise.
  logic [DATA_WIDTH-1:0] do_a_q;
  logic [DATA_WIDTH-1:0] do_b_q;
  logic                  valid_a_q;
  logic                  valid_b_q;
  logic                  coll_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      do_a_q    <= '0;
      do_b_q    <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      valid_a_q <= acc_a;
      valid_b_q <= acc_b;
      coll_q    <= coll_d;
      if (acc_a) do_a_q <= mem_q[ADDRA];
      if (acc_b) do_b_q <= mem_q[ADDRB];
    end
  end

`ifdef BRAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] do_a2_q;
  logic [DATA_WIDTH-1:0] do_b2_q;
  logic                  valid_a2_q;
  logic                  valid_b2_q;
  logic                  coll2_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      do_a2_q    <= '0;
      do_b2_q    <= '0;
      valid_a2_q <= 1'b0;
      valid_b2_q <= 1'b0;
      coll2_q    <= 1'b0;
    end else begin
      valid_a2_q <= valid_a_q;
      valid_b2_q <= valid_b_q;
      coll2_q    <= coll_q;
      if (valid_a_q) do_a2_q <= do_a_q;
      if (valid_b_q) do_b2_q <= do_b_q;
    end
  end

  assign DOA    = do_a2_q;
  assign DOB    = do_b2_q;
  assign VALIDA = valid_a2_q;
  assign VALIDB = valid_b2_q;
  assign COLL   = coll2_q;
`else
  assign DOA    = do_a_q;
  assign DOB    = do_b_q;
  assign VALIDA = valid_a_q;
  assign VALIDB = valid_b_q;
  assign COLL   = coll_q;
`endif

  assign READY = ready;

endmodule
`default_nettype wire

// File: tb/tb_bram_tdp_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_tdp_param
//  Purpose  : Scoreboard bench for bram_tdp_param (ADDR_WIDTH=4, 32-bit).
//             Directed operations push hand-computed expected responses; a
//             negedge monitor pops and compares them when they fall due.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bram_tdp_param;

`ifdef BRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        CLK;
  logic        RST_N;
  logic [3:0]  ADDRA, ADDRB;
  logic [31:0] DIA, DIB;
  logic [3:0]  WEA, WEB;
  logic        ENA, ENB;
  logic [31:0] DOA, DOB;
  logic        VALIDA, VALIDB, READY, COLL;

  bram_tdp_param #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (4)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .ADDRA  (ADDRA),
    .ADDRB  (ADDRB),
    .DIA    (DIA),
    .DIB    (DIB),
    .WEA    (WEA),
    .WEB    (WEB),
    .ENA    (ENA),
    .ENB    (ENB),
    .DOA    (DOA),
    .DOB    (DOB),
    .VALIDA (VALIDA),
    .VALIDB (VALIDB),
    .READY  (READY),
    .COLL   (COLL)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  always @(posedge CLK) cyc_n <= cyc_n + 1;

  typedef struct {
    int          due;
    bit          va;
    logic [31:0] da;
    bit          vb;
    logic [31:0] db;
    bit          coll;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: outputs not covered by a due entry must be idle and holding.
  always @(negedge CLK) begin
    if (!RST_N) begin
      last_a = '0;
      last_b = '0;
    end else begin
      while (sb.size() > 0 && sb[0].due < cyc_n) begin
        chk("sb_stale_entry", 32'(sb[0].due), 32'(cyc_n));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc_n) begin
        me = sb.pop_front();
      end else begin
        me.due = cyc_n; me.va = 0; me.da = '0; me.vb = 0; me.db = '0; me.coll = 0;
      end
      chk("VALIDA", 32'(VALIDA), 32'(me.va));
      chk("VALIDB", 32'(VALIDB), 32'(me.vb));
      chk("COLL",   32'(COLL),   32'(me.coll));
      if (me.va) begin
        chk("DOA", DOA, me.da);
        last_a = me.da;
      end else begin
        chk("DOA_hold", DOA, last_a);
      end
      if (me.vb) begin
        chk("DOB", DOB, me.db);
        last_b = me.db;
      end else begin
        chk("DOB_hold", DOB, last_b);
      end
    end
  end

  // One cycle of stimulus; xa/xb are the hand-computed read-port returns.
  task automatic op(input bit ea, input logic [3:0] wa, input logic [3:0] aa,
                    input logic [31:0] da, input logic [31:0] xa,
                    input bit eb, input logic [3:0] wb, input logic [3:0] ab,
                    input logic [31:0] db, input logic [31:0] xb,
                    input bit xc);
    exp_t e;
    ENA = ea; WEA = wa; ADDRA = aa; DIA = da;
    ENB = eb; WEB = wb; ADDRB = ab; DIB = db;
    if (ea || eb) begin
      e.due = cyc_n + LAT; e.va = ea; e.da = xa; e.vb = eb; e.db = xb; e.coll = xc;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    ENA = 0; ENB = 0; WEA = '0; WEB = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 0; ENA = 0; ENB = 0; WEA = '0; WEB = '0;
    ADDRA = '0; ADDRB = '0; DIA = '0; DIB = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_READY",  32'(READY),  0);
    chk("rst_VALIDA", 32'(VALIDA), 0);
    chk("rst_VALIDB", 32'(VALIDB), 0);
    chk("rst_COLL",   32'(COLL),   0);
    chk("rst_DOA",    DOA,         0);
    chk("rst_DOB",    DOB,         0);

    // Sweep: a write request on A during CLEAR must be ignored.
    ENA = 1; WEA = 4'hF; ADDRA = 4'd2; DIA = 32'hFFFF_FFFF;
    RST_N = 1;
    for (int j = 1; j <= 16; j++) begin
      @(posedge CLK); #1;
      chk($sformatf("sweep_READY_c%0d", j), 32'(READY), (j == 16) ? 1 : 0);
    end
    ENA = 0; WEA = '0;

    // Every word reads back zero, on both ports.
    for (int i = 0; i < 16; i++)
      op(1, 4'h0, 4'(i), 32'h0, 32'h0, 1, 4'h0, 4'(15 - i), 32'h0, 32'h0, 0);
    idle(2);

    // Full-word write, then lane-0-only write, then read.
    op(1, 4'hF, 4'd5, 32'hDEAD_BEEF, 32'h0000_0000, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
    op(1, 4'h1, 4'd5, 32'h0000_00AA, 32'hDEAD_BEEF, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
    op(1, 4'h0, 4'd5, 32'h0,         32'hDEAD_BEAA, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
    idle(2);

    // Write-write collision: A owns lanes 0-1, B keeps lanes 2-3.
    op(1, 4'h3, 4'd7, 32'h1111_1111, 32'h0, 1, 4'hF, 4'd7, 32'h2222_2222, 32'h0, 1);
    op(1, 4'h0, 4'd7, 32'h0, 32'h2222_1111, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
    idle(1);

    // Read-write collision: reader sees the pre-write word.
    op(1, 4'hF, 4'd3, 32'h1234_5678, 32'h0, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
    op(1, 4'h0, 4'd3, 32'h0, 32'h1234_5678, 1, 4'hF, 4'd3, 32'hCAFE_F00D, 32'h1234_5678, 1);
    op(1, 4'h0, 4'd3, 32'h0, 32'hCAFE_F00D, 0, 4'h0, 4'd0, 32'h0, 32'h0, 0);
    idle(1);

    // Read-read on one address: identical data, no collision.
    op(1, 4'h0, 4'd5, 32'h0, 32'hDEAD_BEAA, 1, 4'h0, 4'd5, 32'h0, 32'hDEAD_BEAA, 0);

    // Sparse byte enables on port B.
    op(0, 4'h0, 4'd0, 32'h0, 32'h0, 1, 4'hA, 4'd9, 32'hAABB_CCDD, 32'h0, 0);
    op(1, 4'h0, 4'd5, 32'h0, 32'hDEAD_BEAA, 1, 4'h0, 4'd9, 32'h0, 32'hAA00_CC00, 0);
    idle(LAT + 2);

    // Reset from RUN clears the outputs and restarts the sweep.
    RST_N = 0; #2;
    chk("rst2_READY",  32'(READY),  0);
    chk("rst2_VALIDA", 32'(VALIDA), 0);
    chk("rst2_DOA",    DOA,         0);
    chk("rst2_DOB",    DOB,         0);
    @(posedge CLK); #1;
    RST_N = 1;
    for (int j = 1; j <= 9; j++) begin
      @(posedge CLK); #1;
      chk($sformatf("part_READY_c%0d", j), 32'(READY), 0);
    end
    // Sweep is at address 9: pulse reset again.
    RST_N = 0; #2;
    chk("rst3_READY", 32'(READY), 0);
    @(posedge CLK); #1;
    RST_N = 1;
    for (int j = 1; j <= 16; j++) begin
      @(posedge CLK); #1;
      chk($sformatf("resweep_READY_c%0d", j), 32'(READY), (j == 16) ? 1 : 0);
    end

    // Previously written words are zero again after the restarted sweep.
    op(1, 4'h0, 4'd7, 32'h0, 32'h0, 1, 4'h0, 4'd3, 32'h0, 32'h0, 0);
    op(1, 4'h0, 4'd5, 32'h0, 32'h0, 1, 4'h0, 4'd9, 32'h0, 32'h0, 0);
    idle(LAT + 2);
    chk("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
